// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - dual-port SRAM read initiator packing word pairs into a valid/ready stream
// Optional READER_ADDR_WRAP_EN: transfers past the top of memory wrap instead of being rejected with err.
module sram_stream_reader #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  CENA,
  output logic                  CENB,
  output logic                  WENA,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DA,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  input  logic [BITS-1:0]       QB,
  output logic [2*BITS-1:0]     out_data,
  output logic [1:0]            out_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = 2 * BITS + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [AW1-1:0]        remaining;
  logic                  inflight, inf_hi, inf_last;
  logic                  zero_done, err_q;

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic                  issue, issue_b, pop, credit_ok;
  logic                  req_zero, req_bad, req_go;
  logic [ADDR_WIDTH-1:0] addr_a;

  assign req_zero = (len == '0);

`ifdef READER_ADDR_WRAP_EN
  assign req_bad = 1'b0;
`else
  logic [ADDR_WIDTH+1:0] req_end;
  assign req_end = {2'b00, base} + {1'b0, len};
  assign req_bad = (req_end > ((ADDR_WIDTH+2)'(1) << ADDR_WIDTH));
`endif

  assign req_go = start && !req_zero && !req_bad;

  // Credits: every outstanding read already owns a FIFO slot, so the push never needs out_ready.
  assign credit_ok = ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign {out_last, out_mask, out_data} = fifo_mem[rd_ptr];

  assign addr_a = base_q + offset;
  assign AA     = issue   ? addr_a : '0;
  assign AB     = issue_b ? addr_a + ADDR_WIDTH'(1) : '0;
  assign CENA   = !issue;
  assign CENB   = !issue_b;
  assign WENA   = 1'b1;
  assign WENB   = 1'b1;
  assign DA     = '0;
  assign DB     = '0;
  assign err    = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    issue_b  = 1'b0;
    busy     = (state != IDLE);
    done     = zero_done;
    case (state)
      IDLE: begin
        if (req_go) state_nx = RUN;
      end
      RUN: begin
        if (remaining != '0 && credit_ok) begin
          issue   = 1'b1;
          issue_b = (remaining > AW1'(1));
          if (remaining <= AW1'(2)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base_q     <= '0;
      offset     <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      inf_hi     <= 1'b0;
      inf_last   <= 1'b0;
      zero_done  <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      zero_done <= (state == IDLE) && start && req_zero;
      err_q     <= (state == IDLE) && start && !req_zero && req_bad;
      if (state == IDLE && req_go) begin
        base_q    <= base;
        remaining <= len;
        offset    <= '0;
      end else if (issue) begin
        offset    <= offset + ADDR_WIDTH'(2);
        remaining <= issue_b ? remaining - AW1'(2) : remaining - AW1'(1);
      end
      inflight   <= issue;
      inf_hi     <= issue_b;
      inf_last   <= issue && (remaining <= AW1'(2));
      if (inflight) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(inflight) - CW'(pop);
    end
  end

  // SRAM data is valid the cycle after the enable, which is exactly when inflight is high.
  always_ff @(posedge CLK) begin
    if (inflight) fifo_mem[wr_ptr] <= {inf_last, inf_hi, 1'b1, QB, QA};
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - directed self-checking bench for sram_stream_reader
// Backing SRAM is preloaded with mem[i] = i so every returned word equals its address.
module tb_sram_stream_reader;
  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        busy, done, err;
  logic        CENA, CENB, WENA, WENB;
  logic [9:0]  AA, AB;
  logic [31:0] DA, DB, QA, QB;
  logic [63:0] out_data;
  logic [1:0]  out_mask;
  logic        out_valid, out_ready, out_last;
  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  sram_stream_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .err(err),
    .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(QA), .QB(QB),
    .out_data(out_data), .out_mask(out_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!CENA && WENA) QA <= mem[AA];
    if (!CENB && WENB) QB <= mem[AB];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_cena"}, 64'(CENA), 64'd1);
    check({tag, "_cenb"}, 64'(CENB), 64'd1);
    check({tag, "_aa"}, 64'(AA), 64'd0);
    check({tag, "_ab"}, 64'(AB), 64'd0);
  endtask

  // Starts a transfer and receives it; duty=k means out_ready is high one cycle in k.
  task automatic run_xfer(input string tag, input logic [9:0] b, input logic [10:0] n,
                          input int duty, input bit restart);
    int nbeats = (int'(n) + 1) / 2;
    int got = 0, issues = 0, pops = 0, max_out = 0, cyc = 0, done_cyc = 0;
    bit seen_done = 0;
    logic [31:0] lo, hi;
    logic [1:0]  emask;
    base = b; len = n; start = 1'b1;
    @(negedge CLK);
    start = restart; base = b + 10'd100; len = 11'd2;
    while (!seen_done && cyc < 300) begin
      out_ready = ((cyc % duty) == 0);
      #1;
      if (!CENA) issues++;
      if (issues - pops > max_out) max_out = issues - pops;
      if (out_valid && out_ready) begin
        lo    = 32'((int'(b) + 2 * got) % 1024);
        hi    = 32'((int'(b) + 2 * got + 1) % 1024);
        emask = (2 * got + 1 < int'(n)) ? 2'b11 : 2'b01;
        check({tag, "_mask"}, 64'(out_mask), 64'(emask));
        if (emask == 2'b11) check({tag, "_data"}, out_data, {hi, lo});
        else                check({tag, "_data_lo"}, 64'(out_data[31:0]), 64'(lo));
        check({tag, "_last"}, 64'(out_last), 64'(got == nbeats - 1));
        got++;
        pops++;
      end
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc + 1;
      end
      @(negedge CLK);
      start = 1'b0;
      cyc++;
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    check({tag, "_beats"}, 64'(got), 64'(nbeats));
    check({tag, "_credit"}, 64'(max_out <= 4), 64'd1);
    if (duty == 1) check({tag, "_done_cyc"}, 64'(done_cyc), 64'(nbeats + 2));
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    RST = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
    @(negedge CLK);
    #1 check_reset_outputs("reset");
    check("wena", 64'(WENA), 64'd1);
    check("da", 64'(DA), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // base 8, len 6: cycle-by-cycle
    base = 10'd8; len = 11'd6; start = 1'b1;
    @(negedge CLK); start = 1'b0; #1;
    check("t1_c1_busy", 64'(busy), 64'd1);
    check("t1_c1_cen", 64'({CENA, CENB}), 64'd0);
    check("t1_c1_aa", 64'(AA), 64'd8);
    check("t1_c1_ab", 64'(AB), 64'd9);
    @(negedge CLK); #1;
    check("t1_c2_aa", 64'(AA), 64'd10);
    check("t1_c2_valid", 64'(out_valid), 64'd0);
    @(negedge CLK); #1;
    check("t1_c3_valid", 64'(out_valid), 64'd1);
    check("t1_c3_data", out_data, 64'h00000009_00000008);
    check("t1_c3_mask", 64'(out_mask), 64'd3);
    check("t1_c3_last", 64'(out_last), 64'd0);
    @(negedge CLK); #1;
    check("t1_c4_data", out_data, 64'h0000000b_0000000a);
    check("t1_c4_cena", 64'(CENA), 64'd1);
    check("t1_c4_done", 64'(done), 64'd0);
    @(negedge CLK); #1;
    check("t1_c5_data", out_data, 64'h0000000d_0000000c);
    check("t1_c5_last", 64'(out_last), 64'd1);
    check("t1_c5_done", 64'(done), 64'd1);
    check("t1_c5_busy", 64'(busy), 64'd1);
    @(negedge CLK); #1;
    check("t1_c6_busy", 64'(busy), 64'd0);
    check("t1_c6_done", 64'(done), 64'd0);
    check("t1_c6_valid", 64'(out_valid), 64'd0);

    // base 20, len 3: odd tail
    @(negedge CLK);
    base = 10'd20; len = 11'd3; start = 1'b1;
    @(negedge CLK); start = 1'b0; #1;
    check("t2_c1_aa", 64'(AA), 64'd20);
    check("t2_c1_ab", 64'(AB), 64'd21);
    check("t2_c1_cenb", 64'(CENB), 64'd0);
    @(negedge CLK); #1;
    check("t2_c2_cena", 64'(CENA), 64'd0);
    check("t2_c2_cenb", 64'(CENB), 64'd1);
    check("t2_c2_aa", 64'(AA), 64'd22);
    @(negedge CLK); #1;
    check("t2_c3_data", out_data, 64'h00000015_00000014);
    check("t2_c3_mask", 64'(out_mask), 64'd3);
    check("t2_c3_last", 64'(out_last), 64'd0);
    @(negedge CLK); #1;
    check("t2_c4_lo", 64'(out_data[31:0]), 64'd22);
    check("t2_c4_mask", 64'(out_mask), 64'd1);
    check("t2_c4_last", 64'(out_last), 64'd1);
    check("t2_c4_done", 64'(done), 64'd1);
    @(negedge CLK); #1;
    check("t2_c5_busy", 64'(busy), 64'd0);

    // base 0, len 16 with backpressure
    @(negedge CLK);
    run_xfer("t3", 10'd0, 11'd16, 3, 1'b0);

    // base 1022, len 4 crosses the top of memory
    @(negedge CLK);
`ifdef READER_ADDR_WRAP_EN
    run_xfer("t4", 10'd1022, 11'd4, 1, 1'b0);
`else
    base = 10'd1022; len = 11'd4; start = 1'b1;
    @(negedge CLK); start = 1'b0; #1;
    check("t4_err", 64'(err), 64'd1);
    check("t4_cen", 64'({CENA, CENB}), 64'd3);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    @(negedge CLK); #1;
    check("t4_err_clr", 64'(err), 64'd0);
    check("t4_cen2", 64'({CENA, CENB}), 64'd3);
    check("t4_busy2", 64'(busy), 64'd0);
    check("t4_valid2", 64'(out_valid), 64'd0);
`endif

    // len 0
    @(negedge CLK);
    base = 10'd50; len = 11'd0; start = 1'b1;
    @(negedge CLK); start = 1'b0; #1;
    check("t5_done", 64'(done), 64'd1);
    check("t5_cen", 64'({CENA, CENB}), 64'd3);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_err", 64'(err), 64'd0);
    @(negedge CLK); #1;
    check("t5_done_clr", 64'(done), 64'd0);
    check("t5_busy2", 64'(busy), 64'd0);

    // second start while busy is ignored
    @(negedge CLK);
    run_xfer("t5b", 10'd100, 11'd4, 1, 1'b1);
    @(negedge CLK); #1;
    check("t5b_idle_cena", 64'(CENA), 64'd1);
    check("t5b_idle_busy", 64'(busy), 64'd0);

    // asynchronous reset during the second beat of a len 10 transfer
    @(negedge CLK);
    base = 10'd40; len = 11'd10; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK); #1;
    check("t6_beat2", out_data, 64'h0000002b_0000002a);
    check("t6_busy", 64'(busy), 64'd1);
    #1 RST = 1'b1;
    #1 check_reset_outputs("t6_rst");
    @(negedge CLK); #1;
    check_reset_outputs("t6_hold");
    RST = 1'b0;
    @(negedge CLK);
    run_xfer("t6_after", 10'd300, 11'd2, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
